// File: rtl/sad_pkg.sv
// Shared definitions for the SAD addend packer: lane count, index width,
// element type and the helper that locates a lane inside a packed vector.
package sad_pkg;

    localparam int ELEMENT_BIT_DEPTH = 14;
    localparam int SAD_LANES         = 8;
    localparam int LANE_IDX_WIDTH    = 3;

    typedef logic [ELEMENT_BIT_DEPTH-1:0] lane_elem_t;

    // Bit offset of lane 'lane' in a vector of lanes that are 'elem_w' bits wide
    function automatic int lane_offset(input int lane, input int elem_w);
        return lane * elem_w;
    endfunction

endpackage

// File: rtl/sad_lane_fill_reg.sv
// Eight-lane write-enable register file that collects one element per write.
// group_vec presents the group as it would be completed on the current edge:
// lanes below wr_idx come from storage, lane wr_idx takes wr_data when a
// write is happening, and every lane above is zero-filled.
module sad_lane_fill_reg
    import sad_pkg::*;
#(
    parameter int ELEM_W = ELEMENT_BIT_DEPTH
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [LANE_IDX_WIDTH-1:0]     wr_idx,
    input  logic [ELEM_W-1:0]             wr_data,
    output logic [ELEM_W*SAD_LANES-1:0]   group_vec
);

    logic [ELEM_W-1:0] lane_q [SAD_LANES];

    // Store the incoming element in the lane selected by the fill index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SAD_LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else if (wr_en) begin
            lane_q[wr_idx] <= wr_data;
        end
    end

    // Assemble the completed group with pass-through of the current write and zero-fill above it
    always_comb begin
        group_vec = '0;
        for (int k = 0; k < SAD_LANES; k++) begin
            if (LANE_IDX_WIDTH'(k) < wr_idx) begin
                group_vec[lane_offset(k, ELEM_W) +: ELEM_W] = lane_q[k];
            end else if ((LANE_IDX_WIDTH'(k) == wr_idx) && wr_en) begin
                group_vec[lane_offset(k, ELEM_W) +: ELEM_W] = wr_data;
            end
        end
    end

endmodule

// File: rtl/sad_addend_packer_8.sv
// Serial-to-parallel packer feeding the 8-input SAD adder tree.
// Collects eight elements over the input handshake and holds them as one
// packed vector on the output handshake; counts handed-off groups.
// Optional build macro SAD_PACKER_FLUSH_EN adds in_flush, which completes a
// partial group early with the remaining lanes zero-filled.
module sad_addend_packer_8 #(
    parameter int ELEMENT_BIT_DEPTH = sad_pkg::ELEMENT_BIT_DEPTH,
    parameter int GROUP_CNT_WIDTH   = 16
)
(
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [ELEMENT_BIT_DEPTH-1:0]                 in_data,
`ifdef SAD_PACKER_FLUSH_EN
    input  logic                                         in_flush,
`endif
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [ELEMENT_BIT_DEPTH*sad_pkg::SAD_LANES-1:0] addend_array,
    output logic [GROUP_CNT_WIDTH-1:0]                   group_cnt
);

    import sad_pkg::*;

    localparam int VEC_W = ELEMENT_BIT_DEPTH * SAD_LANES;
    localparam logic [LANE_IDX_WIDTH-1:0] LAST_IDX = LANE_IDX_WIDTH'(SAD_LANES - 1);

    logic [LANE_IDX_WIDTH-1:0] idx;
    logic                      out_free;
    logic                      accept;
    logic                      handoff;
    logic                      flush_fire;
    logic                      complete;
    logic [VEC_W-1:0]          group_vec;

    // The output register can take a new group when it is empty or being drained this cycle
    assign out_free = !out_valid || out_ready;
    // Only the final lane can stall, because only it would overwrite an unconsumed group
    assign in_ready = (idx != LAST_IDX) || out_free;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

`ifdef SAD_PACKER_FLUSH_EN
    // A flush needs something to flush and, like lane 7, a free output register
    assign flush_fire = in_flush && out_free && ((idx != '0) || accept);
`else
    assign flush_fire = 1'b0;
`endif

    assign complete = (accept && (idx == LAST_IDX)) || flush_fire;

    sad_lane_fill_reg #(
        .ELEM_W    (ELEMENT_BIT_DEPTH)
    ) u_fill (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (accept),
        .wr_idx    (idx),
        .wr_data   (in_data),
        .group_vec (group_vec)
    );

    // Fill index advances per accepted element and restarts at lane 0 once a group completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (complete) begin
            idx <= '0;
        end else if (accept) begin
            idx <= idx + LANE_IDX_WIDTH'(1);
        end
    end

    // Output register loads on completion (even during a hand-off, so there is no bubble) and empties on hand-off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            addend_array <= '0;
        end else if (complete) begin
            out_valid    <= 1'b1;
            addend_array <= group_vec;
        end else if (handoff) begin
            out_valid    <= 1'b0;
        end
    end

    // Count handed-off groups, wrapping naturally at the counter width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            group_cnt <= '0;
        end else if (handoff) begin
            group_cnt <= group_cnt + GROUP_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_sad_addend_packer_8.sv
// Self-checking bench for sad_addend_packer_8: a table of per-cycle vectors
// for the first group, then directed sequences for streaming, backpressure,
// lane isolation, input gaps, mid-group reset and (when SAD_PACKER_FLUSH_EN
// is defined) flush.
module tb_sad_addend_packer_8;

    localparam int EW    = 14;
    localparam int CW    = 16;
    localparam int VEC_W = EW * 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [EW-1:0]     in_data;
    logic              in_flush;
    logic              out_valid;
    logic              out_ready;
    logic [VEC_W-1:0]  addend_array;
    logic [CW-1:0]     group_cnt;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [EW-1:0] exp_lane [8];

    typedef struct {
        logic          v;
        logic [EW-1:0] d;
        logic          r;
        logic          exp_in_ready;
        logic          exp_out_valid;
        logic [CW-1:0] exp_cnt;
        logic          chk_arr;
    } vec_t;

    vec_t tbl [9];

    sad_addend_packer_8 #(
        .ELEMENT_BIT_DEPTH (EW),
        .GROUP_CNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
`ifdef SAD_PACKER_FLUSH_EN
        .in_flush     (in_flush),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .addend_array (addend_array),
        .group_cnt    (group_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [EW-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] packExp();
        logic [VEC_W-1:0] vec;
        vec = '0;
        for (int k = 0; k < 8; k++) begin
            vec[k*EW +: EW] = exp_lane[k];
        end
        return vec;
    endfunction

    task automatic expectSeq(input int base);
        for (int k = 0; k < 8; k++) begin
            exp_lane[k] = EW'(base + k);
        end
    endtask

    task automatic feedOne(input logic [EW-1:0] d, input logic r, input string name);
        applyStimulus(1'b1, d, r);
        checkOutput(name, in_ready, 1);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_flush  = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{v: 1'b1, d: EW'(i + 1), r: 1'b1, exp_in_ready: 1'b1,
                       exp_out_valid: (i == 7), exp_cnt: '0, chk_arr: (i == 7)};
        end
        tbl[8] = '{v: 1'b0, d: '0, r: 1'b1, exp_in_ready: 1'b1,
                   exp_out_valid: 1'b0, exp_cnt: CW'(1), chk_arr: 1'b1};

        // reset values
        tick();
        tick();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_addend", addend_array, 0);
        checkOutput("rst_group_cnt", group_cnt, 0);
        rst_n = 1'b1;

        // first group 1..8 from the table, then hand-off
        expectSeq(1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].v, tbl[i].d, tbl[i].r);
            checkOutput("t1_in_ready", in_ready, tbl[i].exp_in_ready);
            tick();
            checkOutput("t1_out_valid", out_valid, tbl[i].exp_out_valid);
            checkOutput("t1_group_cnt", group_cnt, tbl[i].exp_cnt);
            if (tbl[i].chk_arr) checkOutput("t1_addend", addend_array, packExp());
        end

        // continuous stream 100..115 with out_ready held high
        for (int i = 0; i < 16; i++) begin
            feedOne(EW'(100 + i), 1'b1, "t2_in_ready");
            if (i == 7) begin
                expectSeq(100);
                checkOutput("t2_g1_valid", out_valid, 1);
                checkOutput("t2_g1_addend", addend_array, packExp());
            end
            if (i == 8) begin
                checkOutput("t2_g1_drained", out_valid, 0);
                checkOutput("t2_cnt_after_g1", group_cnt, 2);
            end
        end
        expectSeq(108);
        checkOutput("t2_g2_valid", out_valid, 1);
        checkOutput("t2_g2_addend", addend_array, packExp());
        checkOutput("t2_g2_lane0", addend_array[EW-1:0], 108);
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        checkOutput("t2_cnt_final", group_cnt, 3);
        checkOutput("t2_out_valid_idle", out_valid, 0);

        // backpressure: group A held while group B fills, lane 7 stalls
        for (int i = 0; i < 8; i++) feedOne(EW'(200 + i), 1'b0, "t3_a_in_ready");
        expectSeq(200);
        checkOutput("t3_a_valid", out_valid, 1);
        checkOutput("t3_a_addend", addend_array, packExp());
        for (int i = 0; i < 7; i++) feedOne(EW'(300 + i), 1'b0, "t3_b_in_ready");
        applyStimulus(1'b1, EW'(307), 1'b0);
        checkOutput("t3_lane7_stall", in_ready, 0);
        tick();
        tick();
        checkOutput("t3_hold_valid", out_valid, 1);
        checkOutput("t3_hold_addend", addend_array, packExp());
        checkOutput("t3_hold_cnt", group_cnt, 3);
        applyStimulus(1'b1, EW'(307), 1'b1);
        checkOutput("t3_release_in_ready", in_ready, 1);
        tick();
        expectSeq(300);
        checkOutput("t3_b_valid_no_bubble", out_valid, 1);
        checkOutput("t3_b_addend", addend_array, packExp());
        checkOutput("t3_cnt_after_a", group_cnt, 4);
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        checkOutput("t3_b_drained", out_valid, 0);
        checkOutput("t3_cnt_after_b", group_cnt, 5);

        // lane isolation: alternating all-ones / zero, then all-ones everywhere
        for (int i = 0; i < 8; i++) begin
            exp_lane[i] = (i % 2 == 0) ? 14'h3FFF : 14'h0000;
            feedOne(exp_lane[i], 1'b1, "t4_alt_in_ready");
        end
        checkOutput("t4_alt_addend", addend_array, packExp());
        for (int i = 0; i < 8; i++) begin
            exp_lane[i] = 14'h3FFF;
            feedOne(14'h3FFF, 1'b1, "t4_max_in_ready");
        end
        checkOutput("t4_max_valid", out_valid, 1);
        checkOutput("t4_max_addend", addend_array, {VEC_W{1'b1}});
        checkOutput("t4_cnt", group_cnt, 6);
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        checkOutput("t4_cnt_final", group_cnt, 7);

        // in_valid gaps: 3 elements, 5 idle cycles, 5 elements
        for (int i = 0; i < 3; i++) feedOne(EW'(11 + i), 1'b0, "t5_in_ready");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 14'h1555, 1'b0);
            tick();
            checkOutput("t5_gap_out_valid", out_valid, 0);
        end
        for (int i = 3; i < 8; i++) begin
            feedOne(EW'(11 + i), 1'b0, "t5_in_ready");
            if (i == 6) checkOutput("t5_not_early", out_valid, 0);
        end
        expectSeq(11);
        checkOutput("t5_valid", out_valid, 1);
        checkOutput("t5_addend", addend_array, packExp());
        checkOutput("t5_cnt", group_cnt, 7);

        // reset asserted mid-group while a group is still pending
        for (int i = 0; i < 4; i++) feedOne(EW'(90 + i), 1'b0, "t6_pre_in_ready");
        applyStimulus(1'b0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_out_valid", out_valid, 0);
        checkOutput("t6_rst_cnt", group_cnt, 0);
        checkOutput("t6_rst_addend", addend_array, 0);
        checkOutput("t6_rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) feedOne(EW'(20 + i), 1'b1, "t6_in_ready");
        expectSeq(20);
        checkOutput("t6_valid", out_valid, 1);
        checkOutput("t6_addend", addend_array, packExp());
        checkOutput("t6_cnt_before", group_cnt, 0);
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        checkOutput("t6_cnt_after", group_cnt, 1);
        checkOutput("t6_drained", out_valid, 0);

`ifdef SAD_PACKER_FLUSH_EN
        // flush of a partial group zero-fills the upper lanes
        feedOne(EW'(7), 1'b1, "t7_in_ready");
        feedOne(EW'(8), 1'b1, "t7_in_ready");
        feedOne(EW'(9), 1'b1, "t7_in_ready");
        checkOutput("t7_no_early", out_valid, 0);
        in_flush = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        in_flush = 1'b0;
        for (int k = 0; k < 8; k++) exp_lane[k] = '0;
        exp_lane[0] = 7;
        exp_lane[1] = 8;
        exp_lane[2] = 9;
        checkOutput("t7_flush_valid", out_valid, 1);
        checkOutput("t7_flush_addend", addend_array, packExp());
        in_flush = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        in_flush = 1'b0;
        checkOutput("t7_empty_flush_ignored", out_valid, 0);
        checkOutput("t7_cnt", group_cnt, 2);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
